mem_stage_lsu: RTL

Memory-stage load/store unit that consumes the EX/MEM pipeline register outputs. It issues one request per load or store to the data memory over a req/ready handshake, generates byte enables and store-data lane replication, and extracts and sign-extends load data. It stalls the pipeline until the access completes, and flags misaligned, illegal or timed-out accesses.

---
 rtl/mem_stage_lsu_if.sv | 30 +++
 rtl/mem_stage_lsu.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/response bus between the LSU (master) and the data memory (slave).
interface mem_stage_lsu_if;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_RDATA;
  logic        MEM_READY;

  modport master (
    output MEM_REQ,
    output MEM_WE,
    output MEM_ADDR,
    output MEM_WDATA,
    output MEM_BE,
    input  MEM_RDATA,
    input  MEM_READY
  );

  modport slave (
    input  MEM_REQ,
    input  MEM_WE,
    input  MEM_ADDR,
    input  MEM_WDATA,
    input  MEM_BE,
    output MEM_RDATA,
    output MEM_READY
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one data-memory request per load/store, byte-lane
// steering for stores, lane extraction and extension for loads, pipeline stall
// while the access is outstanding, and fault flagging for illegal, misaligned
// or timed-out accesses.
//
//   state  | meaning
//   IDLE   | decode EX/MEM op; issue request or pulse fault
//   ACCESS | request outstanding, waiting for MEM_READY or timeout
//   DONE   | one-cycle completion; LOAD_VALID / timeout fault presented
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  MEM_ACCESS,
  input  logic                  MEM_READ,
  input  logic                  MEM_WRITE,
  input  logic [2:0]            FUNCT3,
  input  logic [31:0]           ALU_OUTPUT,
  input  logic [31:0]           DATA2,
  mem_stage_lsu_if.master       mem,
  output logic                  STALL,
  output logic [31:0]           LOAD_DATA,
  output logic                  LOAD_VALID,
  output logic                  ACCESS_FAULT
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT);

  state_t      state;
  state_t      state_nxt;

  logic        op;
  logic        bad_f3;
  logic        misaligned;
  logic        fault;
  logic        accept;
  logic        ready_hit;
  logic        timeout_hit;
  logic        fault_pulse;
  logic        to_fault_q;
  logic [15:0] to_cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign op = MEM_ACCESS & (MEM_READ | MEM_WRITE);

  // Illegal-encoding and alignment checks on the EX/MEM instruction.
  always_comb begin
    bad_f3 = 1'b0;
    if (MEM_WRITE) begin
      bad_f3 = !(FUNCT3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      bad_f3 = FUNCT3 inside {3'b011, 3'b110, 3'b111};
    end
    misaligned = ((FUNCT3[1:0] == 2'b01) && ALU_OUTPUT[0]) ||
                 ((FUNCT3[1:0] == 2'b10) && (ALU_OUTPUT[1:0] != 2'b00));
    fault = (MEM_READ & MEM_WRITE) | bad_f3 | misaligned;
  end

  // Byte enables and lane-replicated write data for the request about to issue.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = 32'd0;
    if (MEM_WRITE) begin
      case (FUNCT3[1:0])
        2'b00: begin
          be_nxt    = 4'b0001 << ALU_OUTPUT[1:0];
          wdata_nxt = {4{DATA2[7:0]}};
        end
        2'b01: begin
          be_nxt    = ALU_OUTPUT[1] ? 4'b1100 : 4'b0011;
          wdata_nxt = {2{DATA2[15:0]}};
        end
        default: begin
          be_nxt    = 4'b1111;
          wdata_nxt = DATA2;
        end
      endcase
    end
  end

  // Lane selection and sign/zero extension of the returned read word.
  always_comb begin
    case (off_q)
      2'd0:    byte_sel = mem.MEM_RDATA[7:0];
      2'd1:    byte_sel = mem.MEM_RDATA[15:8];
      2'd2:    byte_sel = mem.MEM_RDATA[23:16];
      default: byte_sel = mem.MEM_RDATA[31:24];
    endcase
    half_sel = off_q[1] ? mem.MEM_RDATA[31:16] : mem.MEM_RDATA[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = mem.MEM_RDATA;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus combinational stall and decode-time fault pulse.
  always_comb begin
    state_nxt   = state;
    STALL       = 1'b0;
    fault_pulse = 1'b0;
    accept      = 1'b0;
    ready_hit   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (op && !fault) begin
          accept    = 1'b1;
          STALL     = 1'b1;
          state_nxt = ACCESS;
        end else if (op) begin
          fault_pulse = 1'b1;
        end
      end
      ACCESS: begin
        STALL = 1'b1;
        if (mem.MEM_READY) begin
          ready_hit = 1'b1;
          state_nxt = DONE;
        end else if (({1'b0, to_cnt} + 17'd1) >= TIMEOUT_LIM) begin
          timeout_hit = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        // The EX/MEM register still holds the completed op here, so it is not decoded.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (RESET) begin
      STALL       = 1'b0;
      fault_pulse = 1'b0;
      accept      = 1'b0;
      ready_hit   = 1'b0;
      timeout_hit = 1'b0;
    end
  end

  assign ACCESS_FAULT = fault_pulse | to_fault_q;

  // Request registers, timeout counter and load result.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem.MEM_REQ   <= 1'b0;
      mem.MEM_WE    <= 1'b0;
      mem.MEM_ADDR  <= 32'd0;
      mem.MEM_WDATA <= 32'd0;
      mem.MEM_BE    <= 4'd0;
      LOAD_DATA     <= 32'd0;
      LOAD_VALID    <= 1'b0;
      to_fault_q    <= 1'b0;
      to_cnt        <= 16'd0;
      f3_q          <= 3'd0;
      off_q         <= 2'd0;
    end else begin
      LOAD_VALID <= 1'b0;
      to_fault_q <= 1'b0;
      if (accept) begin
        mem.MEM_REQ   <= 1'b1;
        mem.MEM_WE    <= MEM_WRITE;
        mem.MEM_ADDR  <= {ALU_OUTPUT[31:2], 2'b00};
        mem.MEM_WDATA <= wdata_nxt;
        mem.MEM_BE    <= be_nxt;
        f3_q          <= FUNCT3;
        off_q         <= ALU_OUTPUT[1:0];
        to_cnt        <= 16'd0;
      end
      if (ready_hit) begin
        mem.MEM_REQ <= 1'b0;
        if (!mem.MEM_WE) begin
          LOAD_DATA  <= load_ext;
          LOAD_VALID <= 1'b1;
        end
      end else if (timeout_hit) begin
        mem.MEM_REQ <= 1'b0;
        LOAD_DATA   <= 32'd0;
        LOAD_VALID  <= !mem.MEM_WE;
        to_fault_q  <= 1'b1;
      end else if (state == ACCESS) begin
        to_cnt <= to_cnt + 16'd1;
      end
    end
  end

endmodule
